// File: rtl/rr_handshake_arbiter_pkg.sv
// Shared types and helpers for the round-robin handshake arbiter.
// The state encoding is kept here so sibling bus-handshake blocks can reuse it.
package rr_handshake_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_handshake_arbiter_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick
    import rr_handshake_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Packet-atomic round-robin arbiter: N_REQ valid/ready producers share one
// downstream channel; the owner keeps it until its last beat handshakes.
module rr_handshake_arbiter
    import rr_handshake_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = clog2(N_REQ)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [N_REQ-1:0]        s_valid,
    input  logic [N_REQ*DATA_W-1:0] s_data,
    input  logic [N_REQ-1:0]        s_last,
    output logic [N_REQ-1:0]        s_ready,
    output logic                    m_valid,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    state_e          state_q, state_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic              ownValid, ownLast;
    logic [DATA_W-1:0] ownData;
    logic [ID_W-1:0]   gntInc;
    logic [N_REQ-1:0]  repickReq;
    logic              idleFound, repickFound;
    logic [ID_W-1:0]   idleIdx, repickIdx;

    assign ownValid  = s_valid[gnt_q];
    assign ownLast   = s_last[gnt_q];
    assign ownData   = s_data[int'(gnt_q)*DATA_W +: DATA_W];
    assign gntInc    = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
    // The finishing owner is masked so it cannot immediately win again.
    assign repickReq = s_valid & ~(N_REQ'(1) << gnt_q);

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_idle_pick (
        .req   (s_valid),
        .ptr   (ptr_q),
        .found (idleFound),
        .idx   (idleIdx)
    );

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_repick (
        .req   (repickReq),
        .ptr   (gntInc),
        .found (repickFound),
        .idx   (repickIdx)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        s_ready  = '0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_last   = 1'b0;
        grant_id = '0;
        busy     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (idleFound) begin
                    gnt_d   = idleIdx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                m_valid        = ownValid;
                m_data         = ownData;
                m_last         = ownLast;
                s_ready[gnt_q] = m_ready;
                grant_id       = gnt_q;
                busy           = 1'b1;
                // End of packet: hand over without a bubble if anyone else waits.
                if (ownValid && m_ready && ownLast) begin
                    ptr_d = gntInc;
                    if (repickFound) begin
                        gnt_d = repickIdx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Self-checking bench for rr_handshake_arbiter: directed scenarios plus a
// randomized run compared against a behavioural owner/pointer model.
module tb_rr_handshake_arbiter;

    localparam int N = 4;
    localparam int DW = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [N-1:0]  s_valid = '0;
    logic [N*DW-1:0] s_data = '0;
    logic [N-1:0]  s_last = '0;
    logic [N-1:0]  s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model state: whether a packet owner exists, who, and next priority.
    int mBusy = 0;
    int mOwner = 0;
    int mPtr = 0;

    rr_handshake_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(2)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int pickFrom(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic modelAdvance();
        logic [N-1:0] req;
        int p;
        if (sys_rst) begin
            mBusy = 0; mOwner = 0; mPtr = 0;
        end else if (mBusy == 0) begin
            p = pickFrom(s_valid, mPtr);
            if (p >= 0) begin mBusy = 1; mOwner = p; end
        end else if (s_valid[mOwner] && m_ready && s_last[mOwner]) begin
            mPtr = (mOwner + 1) % N;
            req = s_valid;
            req[mOwner] = 1'b0;
            p = pickFrom(req, mPtr);
            if (p >= 0) mOwner = p;
            else mBusy = 0;
        end
    endtask

    function automatic logic [16:0] modelOutputs();
        logic [N-1:0] rdy;
        rdy = '0;
        if (mBusy == 0) return '0;
        if (m_ready) rdy[mOwner] = 1'b1;
        return {s_valid[mOwner], s_data[mOwner*DW +: DW], s_last[mOwner], rdy, 2'(mOwner), 1'b1};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        modelAdvance();
        #1;
    endtask

    task automatic doReset();
        sys_rst = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b0;
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; s_valid = 4'b1111; s_last = '0; m_ready = 1'b1;
        s_data = 32'h44332211;
        for (int c = 0; c < 3; c++) begin
            tick();
            nCompared++;
            if ({s_ready, m_valid, busy} !== 6'b0) begin
                nMismatched++;
                $display("[TB] FAIL reset_hold cycle %0d: got ready=%b valid=%b busy=%b expected all 0", c, s_ready, m_valid, busy);
            end
        end
        sys_rst = 1'b0;
        #1;
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_release_latency: got busy=%b expected 0", busy); end
        tick();
        nCompared++;
        if ({busy, grant_id} !== 3'b100) begin
            nMismatched++;
            $display("[TB] FAIL reset_first_grant: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] beats [3];
        beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
        doReset();
        s_valid = 4'b0010; m_ready = 1'b1; s_last = '0; s_data = '0;
        tick();
        for (int b = 0; b < 3; b++) begin
            s_data[15:8] = beats[b];
            s_last[1] = (b == 2);
            #1;
            nCompared++;
            if ({m_valid, m_data, m_last, s_ready} !== {1'b1, beats[b], (b == 2), 4'b0010}) begin
                nMismatched++;
                $display("[TB] FAIL single_beat%0d: got v=%b d=%h l=%b r=%b expected v=1 d=%h l=%b r=0010",
                         b, m_valid, m_data, m_last, s_ready, beats[b], (b == 2));
            end
            tick();
        end
        s_valid = '0;
        #1;
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_idle_after: got busy=%b expected 0", busy); end
        // ptr should now be 2, so an all-request pick lands on requester 2.
        s_valid = 4'b1111; s_last = 4'b1111;
        tick();
        nCompared++;
        if (grant_id !== 2'd2) begin nMismatched++; $display("[TB] FAIL single_ptr_next: got id=%0d expected 2", grant_id); end
    endtask

    task automatic test_backpressure();
        doReset();
        s_valid = 4'b0010; m_ready = 1'b1; s_last = '0; s_data = '0;
        s_data[15:8] = 8'hA1;
        tick();
        tick();
        s_data[15:8] = 8'hA2; m_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            nCompared++;
            if ({m_valid, m_data, s_ready} !== {1'b1, 8'hA2, 4'b0000}) begin
                nMismatched++;
                $display("[TB] FAIL bp_stall%0d: got v=%b d=%h r=%b expected v=1 d=a2 r=0000", c, m_valid, m_data, s_ready);
            end
            tick();
        end
        m_ready = 1'b1;
        #1;
        nCompared++;
        if ({m_data, s_ready} !== {8'hA2, 4'b0010}) begin
            nMismatched++;
            $display("[TB] FAIL bp_resume: got d=%h r=%b expected d=a2 r=0010", m_data, s_ready);
        end
        tick();
        s_data[15:8] = 8'hA3; s_last[1] = 1'b1;
        #1;
        nCompared++;
        if ({m_valid, m_data, m_last} !== {1'b1, 8'hA3, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL bp_last_beat: got v=%b d=%h l=%b expected v=1 d=a3 l=1", m_valid, m_data, m_last);
        end
        tick();
        s_valid = '0;
        #1;
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_idle_after: got busy=%b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        doReset();
        s_valid = 4'b1111; s_last = 4'b1111; m_ready = 1'b1; s_data = 32'h40302010;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            nCompared++;
            if ({busy, grant_id, s_ready, m_data} !== {1'b1, 2'(i % 4), 4'(1 << (i % 4)), 8'((i % 4 + 1) * 16)}) begin
                nMismatched++;
                $display("[TB] FAIL rr_slot%0d: got busy=%b id=%0d r=%b d=%h expected busy=1 id=%0d",
                         i, busy, grant_id, s_ready, m_data, i % 4);
            end
            tick();
        end
    endtask

    task automatic test_atomicity();
        doReset();
        s_valid = 4'b0001; s_last = '0; m_ready = 1'b1; s_data = 32'h00CC0055;
        tick();
        for (int b = 1; b <= 4; b++) begin
            if (b == 2) s_valid[2] = 1'b1;
            if (b == 4) s_last[0] = 1'b1;
            #1;
            nCompared++;
            if ({grant_id, s_ready} !== {2'd0, 4'b0001}) begin
                nMismatched++;
                $display("[TB] FAIL atomic_beat%0d: got id=%0d r=%b expected id=0 r=0001", b, grant_id, s_ready);
            end
            tick();
        end
        #1;
        nCompared++;
        if ({busy, grant_id, s_ready, m_data} !== {1'b1, 2'd2, 4'b0100, 8'hCC}) begin
            nMismatched++;
            $display("[TB] FAIL atomic_handover: got busy=%b id=%0d r=%b d=%h expected busy=1 id=2 r=0100 d=cc",
                     busy, grant_id, s_ready, m_data);
        end
        s_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        doReset();
        s_valid = 4'b0011; s_last = 4'b0001; m_ready = 1'b1; s_data = 32'h0000B2B1;
        tick();
        tick();
        nCompared++;
        if (grant_id !== 2'd1) begin nMismatched++; $display("[TB] FAIL rmid_owner: got id=%0d expected 1", grant_id); end
        tick();
        tick();
        sys_rst = 1'b1;
        tick();
        nCompared++;
        if ({s_ready, m_valid, m_data, m_last, grant_id, busy} !== 17'b0) begin
            nMismatched++;
            $display("[TB] FAIL rmid_outputs: got r=%b v=%b d=%h l=%b id=%0d busy=%b expected all 0",
                     s_ready, m_valid, m_data, m_last, grant_id, busy);
        end
        sys_rst = 1'b0;
        tick();
        nCompared++;
        if ({busy, grant_id} !== 3'b100) begin
            nMismatched++;
            $display("[TB] FAIL rmid_restart: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id);
        end
    endtask

    task automatic test_random();
        logic [16:0] expVec;
        doReset();
        for (int c = 0; c < 800; c++) begin
            sys_rst = ($urandom_range(0, 59) == 0);
            s_valid = 4'($urandom);
            s_data  = $urandom;
            s_last  = 4'($urandom) & 4'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            expVec = modelOutputs();
            nCompared++;
            if ({m_valid, m_data, m_last, s_ready, grant_id, busy} !== expVec) begin
                nMismatched++;
                $display("[TB] FAIL random_cycle%0d: got {v,d,l,r,id,busy}=%h expected %h",
                         c, {m_valid, m_data, m_last, s_ready, grant_id, busy}, expVec);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_backpressure();
        test_round_robin();
        test_atomicity();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
